// File: rtl/mem_ctrl.sv
// mem_ctrl: memory-side responder for the icache fill port and the load/store
// port. Each 32-bit request is turned into byte accesses on the RAM bus.
// Reads have one cycle of latency and writes take one cycle per byte.
// Read bytes are assembled little-endian. One valid pulse is returned per
// completed request.
module mem_ctrl #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  ic_ena,
  input  logic [ADDR_WIDTH-1:0] ic_addr,
  output logic                  ic_valid,
  output logic [31:0]           ic_data,
  input  logic                  ls_ena,
  input  logic                  ls_wr,
  input  logic [1:0]            ls_len,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [31:0]           ls_wdata,
  output logic                  ls_valid,
  output logic [31:0]           ls_rdata,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  output logic [7:0]            mem_dout,
  input  logic [7:0]            mem_din
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Byte count for a load/store size code; the unused code 10 means a full word.
  function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
    logic [2:0] n;
    case (len)
      2'b00:   n = 3'd1;
      2'b01:   n = 3'd2;
      2'b11:   n = 3'd4;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  // Select little-endian byte idx of a word.
  function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Replace little-endian byte idx of a word.
  function automatic logic [31:0] put_byte(input logic [31:0] word, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] w;
    w = word;
    case (idx)
      2'd0:    w[7:0]   = b;
      2'd1:    w[15:8]  = b;
      2'd2:    w[23:16] = b;
      2'd3:    w[31:24] = b;
      default: w = word;
    endcase
    return w;
  endfunction

  // Sequencer state and request context.
  state_t                state_r;
  state_t                state_nxt_s;
  logic [ADDR_WIDTH-1:0] base_r;
  logic [ADDR_WIDTH-1:0] base_nxt_s;
  logic [2:0]            nbytes_r;
  logic [2:0]            nbytes_nxt_s;
  logic [31:0]           wdata_r;
  logic [31:0]           wdata_nxt_s;
  logic                  owner_r;       // 1 = load/store port, 0 = icache
  logic                  owner_nxt_s;
  logic [2:0]            cnt_r;         // cycles spent in READ/WRITE so far
  logic [2:0]            cnt_nxt_s;
  logic [31:0]           buf_r;         // partially assembled read word
  logic [31:0]           buf_nxt_s;

  // Next values of the registered outputs.
  logic [ADDR_WIDTH-1:0] mem_a_nxt_s;
  logic                  mem_wr_nxt_s;
  logic [7:0]            mem_dout_nxt_s;
  logic                  ic_valid_nxt_s;
  logic [31:0]           ic_data_nxt_s;
  logic                  ls_valid_nxt_s;
  logic [31:0]           ls_rdata_nxt_s;

  // Helpers: the next byte index to issue, the index of the byte arriving now,
  // and the buffer with the arriving byte merged in.
  logic [2:0]  nxt_idx_s;
  logic [1:0]  rd_idx_s;
  logic [31:0] merged_s;

  assign nxt_idx_s = cnt_r + 3'd1;
  assign rd_idx_s  = cnt_r[1:0] - 2'd1;
  assign merged_s  = put_byte(buf_r, rd_idx_s, mem_din);

  // Next-state and next-output decode for the request sequencer.
  always_comb begin
    state_nxt_s    = state_r;
    base_nxt_s     = base_r;
    nbytes_nxt_s   = nbytes_r;
    wdata_nxt_s    = wdata_r;
    owner_nxt_s    = owner_r;
    cnt_nxt_s      = cnt_r;
    buf_nxt_s      = buf_r;
    mem_a_nxt_s    = mem_a;
    mem_wr_nxt_s   = 1'b0;
    mem_dout_nxt_s = mem_dout;
    ic_valid_nxt_s = 1'b0;
    ic_data_nxt_s  = ic_data;
    ls_valid_nxt_s = 1'b0;
    ls_rdata_nxt_s = ls_rdata;

    case (state_r)
      IDLE: begin
        if (ls_ena) begin
          // Load/store wins over the icache when both are pending.
          owner_nxt_s  = 1'b1;
          base_nxt_s   = ls_addr;
          nbytes_nxt_s = len_to_bytes(ls_len);
          wdata_nxt_s  = ls_wdata;
          cnt_nxt_s    = 3'd0;
          buf_nxt_s    = 32'h0000_0000;
          mem_a_nxt_s  = ls_addr;
          if (ls_wr) begin
            mem_wr_nxt_s   = 1'b1;
            mem_dout_nxt_s = ls_wdata[7:0];
            state_nxt_s    = WRITE;
          end else begin
            state_nxt_s    = READ;
          end
        end else if (ic_ena) begin
          owner_nxt_s  = 1'b0;
          base_nxt_s   = ic_addr;
          nbytes_nxt_s = 3'd4;
          wdata_nxt_s  = wdata_r;
          cnt_nxt_s    = 3'd0;
          buf_nxt_s    = 32'h0000_0000;
          mem_a_nxt_s  = ic_addr;
          state_nxt_s  = READ;
        end else begin
          state_nxt_s  = IDLE;
        end
      end

      READ: begin
        cnt_nxt_s = nxt_idx_s;
        // The byte addressed in the previous cycle arrives now.
        if (cnt_r != 3'd0) begin
          buf_nxt_s = merged_s;
        end else begin
          buf_nxt_s = buf_r;
        end
        // Keep issuing addresses until all N bytes have been requested.
        if (nxt_idx_s < nbytes_r) begin
          mem_a_nxt_s = base_r + ADDR_WIDTH'(nxt_idx_s);
        end else begin
          mem_a_nxt_s = mem_a;
        end
        if (cnt_r == nbytes_r) begin
          state_nxt_s = DONE;
          if (owner_r) begin
            ls_valid_nxt_s = 1'b1;
            ls_rdata_nxt_s = merged_s;
          end else begin
            ic_valid_nxt_s = 1'b1;
            ic_data_nxt_s  = merged_s;
          end
        end else begin
          state_nxt_s = READ;
        end
      end

      WRITE: begin
        if (nxt_idx_s < nbytes_r) begin
          cnt_nxt_s      = nxt_idx_s;
          mem_a_nxt_s    = base_r + ADDR_WIDTH'(nxt_idx_s);
          mem_wr_nxt_s   = 1'b1;
          mem_dout_nxt_s = byte_sel(wdata_r, nxt_idx_s[1:0]);
          state_nxt_s    = WRITE;
        end else begin
          mem_wr_nxt_s   = 1'b0;
          ls_valid_nxt_s = 1'b1;
          state_nxt_s    = DONE;
        end
      end

      DONE: begin
        // Requests are not sampled here; the requester updates on the valid edge.
        state_nxt_s = IDLE;
      end

      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register; holds while the system is frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else if (rdy) begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath and output registers. A freeze holds everything but drops the
  // write strobe so the current byte is not written a second time.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_r   <= '0;
      nbytes_r <= 3'd0;
      wdata_r  <= 32'h0000_0000;
      owner_r  <= 1'b0;
      cnt_r    <= 3'd0;
      buf_r    <= 32'h0000_0000;
      mem_a    <= '0;
      mem_wr   <= 1'b0;
      mem_dout <= 8'h00;
      ic_valid <= 1'b0;
      ic_data  <= 32'h0000_0000;
      ls_valid <= 1'b0;
      ls_rdata <= 32'h0000_0000;
    end else if (!rdy) begin
      mem_wr   <= 1'b0;
    end else begin
      base_r   <= base_nxt_s;
      nbytes_r <= nbytes_nxt_s;
      wdata_r  <= wdata_nxt_s;
      owner_r  <= owner_nxt_s;
      cnt_r    <= cnt_nxt_s;
      buf_r    <= buf_nxt_s;
      mem_a    <= mem_a_nxt_s;
      mem_wr   <= mem_wr_nxt_s;
      mem_dout <= mem_dout_nxt_s;
      ic_valid <= ic_valid_nxt_s;
      ic_data  <= ic_data_nxt_s;
      ls_valid <= ls_valid_nxt_s;
      ls_rdata <= ls_rdata_nxt_s;
    end
  end

endmodule
